// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : payload bytes packed into one memory word
//   LEN_BYTES      : header bytes carrying the little-endian word count
//   accepts_bytes  : states in which the loader offers rx_ready
package prog_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words.
//   clk, rst   : clock, async active-high reset
//   data/valid : byte and its accept strobe (only asserted on a real transfer)
//   last_c     : combinational, next accepted byte completes a word
//   word       : last completed word, held until the next one completes
//   word_valid : one-cycle pulse in the cycle after a word completes
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   data,
  input  logic                valid,
  output logic                last_c,
  output logic [WORD_W-1:0]   word,
  output logic                word_valid
);

  localparam int unsigned SR_W = WORD_W - BYTE_W;

  logic [1:0]      cnt;
  logic [SR_W-1:0] sr;

  assign last_c = (cnt == 2'(BYTES_PER_WORD - 1));

  // Bytes enter at the top so the first byte ends up in the lowest lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (valid) begin
        cnt <= cnt + 2'(1);
        sr  <= {data, sr[SR_W-1:BYTE_W]};
        if (last_c) begin
          word       <= {data, sr};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: reads a length header and a payload, writes
// packed words into instruction/data memory, then releases the CPU.
//   clk, rst             : clock, async active-high reset
//   rx_data/rx_valid     : input byte stream
//   rx_ready             : byte accepted this cycle when rx_valid is high
//   mem_we/addr/wdata    : registered memory write port (addr/wdata held)
//   cpu_rstn             : active-low CPU reset, 1 once the image is loaded
//   load_done / load_err : sticky completion / abort flags
//   words_loaded         : number of words written so far
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                cpu_rstn,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] len_lo;
  logic [LEN_W-1:0]  frame_len;
  logic [LEN_W-1:0]  n_hdr;
  logic              xfer;
  logic              pk_last_c;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign xfer  = rx_valid & rx_ready;
  assign n_hdr = {rx_data, len_lo};

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .data       (rx_data),
    .valid      (xfer && (state == DATA)),
    .last_c     (pk_last_c),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LEN_LO;
    else     state <= state_nxt;
  end

  // Next-state logic; words_loaded is already incremented during WRITE.
  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (n_hdr == '0)                    state_nxt = DONE;
          else if (32'(n_hdr) > MAX_WORDS)    state_nxt = ERR;
          else                                state_nxt = DATA;
        end
      end
      DATA:   if (xfer && pk_last_c) state_nxt = WRITE;
      WRITE: begin
        if (32'(words_loaded) == 32'(frame_len)) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM:   if (xfer) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
      DONE:   state_nxt = DONE;
      ERR:    state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  // Registered status outputs follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready  <= 1'b1;
      cpu_rstn  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_ready  <= accepts_bytes(state_nxt);
      cpu_rstn  <= (state_nxt == DONE);
      load_done <= (state_nxt == DONE);
      load_err  <= (state_nxt == ERR);
    end
  end

  // Header capture, word counter and address generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo       <= '0;
      frame_len    <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
    end else begin
      if ((state == LEN_LO) && xfer) len_lo    <= rx_data;
      if ((state == LEN_HI) && xfer) frame_len <= n_hdr;
      if ((state == DATA) && (state_nxt == WRITE)) begin
        mem_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over payload bytes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       csum <= '0;
    else if ((state == DATA) && xfer) csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized
// payloads and rx_valid gaps, checked against a word-level model of the
// expected memory image.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rstn;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          ready_bad = 0;
  logic [7:0]  pl[$];

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rstn     (cpu_rstn),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record writes; while loading, rx_ready must be low exactly when mem_we is high.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (!rst && !load_done && !load_err && (rx_ready === mem_we)) ready_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      if (rx_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_flags", {30'd0, load_done, load_err}, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pl_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x ^= pl[i];
    return x;
  endfunction

  // gapmode: 0 back-to-back, 1 one idle cycle per byte, 2 random idle cycles
  function automatic int gap_of(input int gapmode);
    if (gapmode == 1) return 1;
    if (gapmode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic send_frame(input int n, input int gapmode, input bit with_csum);
    send_byte(8'(n), gap_of(gapmode));
    send_byte(8'(n >> 8), gap_of(gapmode));
    for (int i = 0; i < 4 * n; i++) send_byte(pl[i], gap_of(gapmode));
`ifdef LOADER_CHECKSUM_EN
    if (with_csum) send_byte(pl_xor(n), gap_of(gapmode));
`endif
  endtask

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
  endtask

  // Expected image: word i holds payload bytes 4i..4i+3, lowest byte first.
  task automatic check_writes(input string tag, input int base, input int n);
    chk({tag, "_nwr"}, 32'(wa.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), wa[base + i], BASE + 32'(4 * i));
        chk($sformatf("%s_data%0d", tag, i), wd[base + i],
            {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]});
      end
    end
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int rb;
    int n;

    // Power-on reset
    @(negedge clk);
    chk("por_rx_ready", 32'(rx_ready), 32'd1);
    chk("por_cpu_rstn", 32'(cpu_rstn), 32'd0);
    do_reset();

    // 1) three-word image, exact write and release latency
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
           8'h73, 8'h00, 8'h10, 8'h00};
    base = wa.size();
    rb = ready_bad;
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 12; i++) send_byte(pl[i], 0);
    chk("t1_last_we", 32'(mem_we), 32'd1);
    chk("t1_last_rdy", 32'(rx_ready), 32'd0);
    chk("t1_rstn_held", 32'(cpu_rstn), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(pl_xor(3), 0);
    chk("t1_rstn", 32'(cpu_rstn), 32'd1);
`else
    wait_cycles(1);
    chk("t1_rstn", 32'(cpu_rstn), 32'd1);
    chk("t1_we_off", 32'(mem_we), 32'd0);
    // Trailing byte must stay unconsumed in DONE
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    wait_cycles(3);
    chk("t1_trail_rdy", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
`endif
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_words", 32'(words_loaded), 32'd3);
    check_writes("t1", base, 3);
    chk("t1_ready_rule", 32'(ready_bad - rb), 32'd0);

    // 2) empty image
    do_reset();
    base = wa.size();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t2_rstn", 32'(cpu_rstn), 32'd1);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_rdy", 32'(rx_ready), 32'd0);
    wait_cycles(2);
    chk("t2_nwr", 32'(wa.size() - base), 32'd0);

    // 3) oversize length 2**ADDR_W+1
    do_reset();
    base = wa.size();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_rdy", 32'(rx_ready), 32'd0);
    chk("t3_rstn", 32'(cpu_rstn), 32'd0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    wait_cycles(8);
    rx_valid = 1'b0;
    chk("t3_nwr", 32'(wa.size() - base), 32'd0);
    chk("t3_words", 32'(words_loaded), 32'd0);
    chk("t3_done", 32'(load_done), 32'd0);

    // 4) N=2 random payload with rx_valid toggling every cycle
    do_reset();
    fill_random(2);
    base = wa.size();
    rb = ready_bad;
    send_frame(2, 1, 1'b1);
    wait_cycles(2);
    check_writes("t4", base, 2);
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_ready_rule", 32'(ready_bad - rb), 32'd0);

    // 5) reset mid-load, then a fresh one-word frame
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_rstn", 32'(cpu_rstn), 32'd0);
    chk("t5_rst_words", 32'(words_loaded), 32'd0);
    chk("t5_rst_rdy", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    base = wa.size();
    send_frame(1, 0, 1'b1);
    wait_cycles(2);
    check_writes("t5", base, 1);
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_rstn", 32'(cpu_rstn), 32'd1);

    // Randomized short frames with random gaps
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = int'($urandom_range(1, 9));
      fill_random(n);
      base = wa.size();
      rb = ready_bad;
      send_frame(n, 2, 1'b1);
      wait_cycles(2);
      check_writes($sformatf("rnd%0d", r), base, n);
      chk($sformatf("rnd%0d_words", r), 32'(words_loaded), 32'(n));
      chk($sformatf("rnd%0d_done", r), 32'(load_done), 32'd1);
      chk($sformatf("rnd%0d_ready_rule", r), 32'(ready_bad - rb), 32'd0);
    end

    // Full memory: N = 2**ADDR_W, last write at word 2**ADDR_W-1
    do_reset();
    n = 1 << ADDR_W;
    fill_random(n);
    base = wa.size();
    send_frame(n, 0, 1'b1);
    wait_cycles(2);
    check_writes("full", base, n);
    chk("full_words", 32'(words_loaded), 32'(n));
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_err", 32'(load_err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // 6) checksum match and mismatch
    do_reset();
    pl = '{8'h01, 8'h02, 8'h04, 8'h08};
    send_frame(1, 0, 1'b0);
    wait_cycles(1);
    chk("t6_wait_csum", 32'(load_done), 32'd0);
    chk("t6_csum_rdy", 32'(rx_ready), 32'd1);
    send_byte(8'h0F, 0);
    chk("t6_good_done", 32'(load_done), 32'd1);
    chk("t6_good_rstn", 32'(cpu_rstn), 32'd1);
    do_reset();
    send_frame(1, 0, 1'b0);
    send_byte(8'h0E, 0);
    chk("t6_bad_err", 32'(load_err), 32'd1);
    chk("t6_bad_rstn", 32'(cpu_rstn), 32'd0);
    chk("t6_bad_done", 32'(load_done), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
